// File: rtl/barrett_reduce_8.sv
// Three-stage pipelined Barrett reduction of a 2K-bit product modulo a K-bit modulus, valid/ready on both sides.
// Optional range check: define BARRETT_RANGE_CHK_EN to flag operands outside the Barrett range on out_err.
module barrett_reduce_8 #(
  parameter int K = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*K-1:0] in_p,
  input  logic [K-1:0]   in_m,
  input  logic [K:0]     in_mu,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K-1:0]   out_z,
  output logic           out_err
);
  logic           en;
  logic           s1_valid, s2_valid;
  logic [2*K+2:0] s1_q2;
  logic [K+1:0]   s1_p, s2_r;
  logic [K-1:0]   s1_m, s2_m;

  logic [K+1:0]   mu_eff_c;
  logic [K:0]     q1_c, q3_c;
  logic [2*K+2:0] q2_c;
  logic [K+1:0]   qm_c, r_c, m_ext_c, r1_c, r2_c;

  // A stalled output freezes every stage, so the whole pipe shares one enable.
  assign en       = !out_valid || out_ready;
  assign in_ready = RST || en;

  // For M = 2^(K-1), mu = 2^(K+1) does not fit the mu port; substitute it here.
  assign mu_eff_c = (in_m == {1'b1, {(K-1){1'b0}}}) ? {1'b1, {(K+1){1'b0}}}
                                                   : {1'b0, in_mu};
  assign q1_c     = (K+1)'(in_p >> (K-1));
  assign q2_c     = {{(K+2){1'b0}}, q1_c} * {{(K+1){1'b0}}, mu_eff_c};

  // The remainder estimate is below 3M, so only the low K+2 bits of q3*M matter.
  assign q3_c     = (K+1)'(s1_q2 >> (K+1));
  assign qm_c     = {1'b0, q3_c} * {2'b00, s1_m};
  assign r_c      = s1_p - qm_c;

  assign m_ext_c  = {2'b00, s2_m};
  assign r1_c     = (s2_r >= m_ext_c) ? s2_r - m_ext_c : s2_r;
  assign r2_c     = (r1_c >= m_ext_c) ? r1_c - m_ext_c : r1_c;

  // NOTE: non-blocking assignments so each stage captures the previous-cycle value of the one before it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) out_z <= K'(r2_c);
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge CLK) begin
    if (en) begin
      s1_q2 <= q2_c;
      s1_p  <= in_p[K+1:0];
      s1_m  <= in_m;
      s2_r  <= r_c;
      s2_m  <= s1_m;
    end
  end

`ifdef BARRETT_RANGE_CHK_EN
  logic [2*K-1:0] mm_c;
  logic           in_err_c, s1_err, s2_err;

  assign mm_c     = {{K{1'b0}}, in_m} * {{K{1'b0}}, in_m};
  assign in_err_c = !in_m[K-1] || (in_p >= mm_c);

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_err <= 1'b0;
    end else if (en) begin
      s1_err <= in_err_c;
      s2_err <= s1_err;
      if (s2_valid) out_err <= s2_err;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_barrett_reduce_8.sv
// Directed self-checking bench for barrett_reduce_8: latency, back-to-back, backpressure, bubbles, reset flush.
module tb_barrett_reduce_8;
  localparam int K = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic           in_valid;
  logic           in_ready;
  logic [2*K-1:0] in_p;
  logic [K-1:0]   in_m;
  logic [K:0]     in_mu;
  logic           out_valid;
  logic           out_ready;
  logic [K-1:0]   out_z;
  logic           out_err;

  int checks = 0;
  int errors = 0;
  logic err_exp;

  barrett_reduce_8 #(.K(K)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_m(in_m), .in_mu(in_mu),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_err(out_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, input int p, input int m, input int mu);
    in_valid = v;
    in_p     = p[2*K-1:0];
    in_m     = m[K-1:0];
    in_mu    = mu[K:0];
  endtask

  // One isolated transfer with out_ready held high: result visible after the third edge.
  task automatic run_one(input string tag, input int p, input int m, input int mu,
                         input int exp_z, input logic exp_err, input logic chk_z);
    drive(1'b1, p, m, mu);
    step();
    drive(1'b0, 0, m, mu);
    check({tag, "_lat1"}, out_valid, 0);
    step();
    check({tag, "_lat2"}, out_valid, 0);
    step();
    check({tag, "_valid"}, out_valid, 1);
    if (chk_z) check({tag, "_z"}, out_z, exp_z);
    check({tag, "_err"}, out_err, exp_err);
    step();
  endtask

  initial begin
`ifdef BARRETT_RANGE_CHK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    RST = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0);
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    RST = 1'b0;
    step();
    check("idle_in_ready", in_ready, 1);

    run_one("m251_p62500", 62500, 251, 261, 1, 1'b0, 1'b1);

    // Back-to-back pair at full throughput, then a bubble that must leave out_z alone.
    drive(1'b1, 0, 251, 261);
    step();
    drive(1'b1, 63000, 251, 261);
    step();
    drive(1'b0, 0, 251, 261);
    step();
    check("b2b_v0", out_valid, 1);
    check("b2b_z0", out_z, 0);
    step();
    check("b2b_v1", out_valid, 1);
    check("b2b_z1", out_z, 250);
    step();
    check("b2b_drain", out_valid, 0);
    check("bubble_hold_z", out_z, 250);

    run_one("m128_p12345", 12345, 128, 512, 57, 1'b0, 1'b1);
    run_one("m128_p16383", 16383, 128, 512, 127, 1'b0, 1'b1);
    run_one("m127_range", 100, 127, 516, 0, err_exp, 1'b0);
    run_one("p_eq_mm", 63001, 251, 261, 0, err_exp, 1'b0);
    run_one("m255_p65024", 65024, 255, 257, 254, 1'b0, 1'b1);
    run_one("m200_p39999", 39999, 200, 327, 199, 1'b0, 1'b1);

    // Backpressure: three accepted, output stalled for four cycles, then drained in order.
    out_ready = 1'b0;
    drive(1'b1, 62500, 251, 261);
    step();
    check("bp_accept_b", in_ready, 1);
    drive(1'b1, 63000, 251, 261);
    step();
    drive(1'b1, 12345, 128, 512);
    step();
    drive(1'b0, 0, 128, 512);
    check("bp_first_v", out_valid, 1);
    check("bp_first_z", out_z, 1);
    check("bp_stall_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_v", out_valid, 1);
      check("bp_hold_z", out_z, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("bp_second_v", out_valid, 1);
    check("bp_second_z", out_z, 250);
    step();
    check("bp_third_v", out_valid, 1);
    check("bp_third_z", out_z, 57);
    step();
    check("bp_drain", out_valid, 0);

    // Mid-operation reset with two items in flight and in_valid high during reset.
    drive(1'b1, 62500, 251, 261);
    step();
    drive(1'b1, 63000, 251, 261);
    step();
    drive(1'b1, 16383, 128, 512);
    RST = 1'b1;
    #1;
    check("mrst_in_ready", in_ready, 1);
    step();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_z", out_z, 0);
    RST = 1'b0;
    drive(1'b0, 0, 128, 512);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mrst_flushed", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
